// File: rtl/spad_event_capture.sv
// SPAD event capture: synchronises trig/time_gate, timestamps photons against a
// window counter started by TDC_start, queues events in a small FIFO, drives rst_auto.
module spad_event_capture #(
    parameter int CNT_W      = 10,
    parameter int WINDOW_CYC = 512,
    parameter int RST_CYC    = 2,
    parameter int MAX_EVT    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_250M,
    input  logic               rst_n,
    input  logic               TDC_start,
    input  logic               trig,
    input  logic               time_gate,
    input  logic [15:0]        spad_int,
    output logic               rst_auto,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CNT_W+17:0]  evt_data,
    output logic               win_done,
    output logic               evt_drop
);

    localparam int EVT_W  = CNT_W + 18;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int HOLD_W = $clog2(RST_CYC + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_REARM = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detectors
    // ------------------------------------------------------------------
    logic trig_m_q, trig_s_q, trig_s_d_q;
    logic gate_m_q, gate_s_q;
    logic start_d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            trig_m_q   <= 1'b0;
            trig_s_q   <= 1'b0;
            trig_s_d_q <= 1'b0;
            gate_m_q   <= 1'b0;
            gate_s_q   <= 1'b0;
            start_d_q  <= 1'b0;
        end else begin
            trig_m_q   <= trig;
            trig_s_q   <= trig_m_q;
            trig_s_d_q <= trig_s_q;
            gate_m_q   <= time_gate;
            gate_s_q   <= gate_m_q;
            start_d_q  <= TDC_start;
        end
    end

    logic trig_rise, start_rise;
    assign trig_rise  = trig_s_q & ~trig_s_d_q;
    assign start_rise = TDC_start & ~start_d_q;

    // ------------------------------------------------------------------
    // Window FSM, counter, event index, re-arm control
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        evt_idx_q, evt_idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rst_auto_q, rst_auto_d;

    logic       active, win_last, hold_done, push_req;
    logic [1:0] evt_idx_inc;

    assign active      = (state_q != S_IDLE);
    assign win_last    = active && (cnt_q == CNT_W'(WINDOW_CYC - 1));
    // rst_auto has been high for RST_CYC cycles once the current cycle completes.
    assign hold_done   = rst_auto_q && (hold_q >= HOLD_W'(RST_CYC - 1));
    assign push_req    = (state_q == S_ARMED) && trig_rise;
    assign evt_idx_inc = evt_idx_q + 2'd1;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        evt_idx_d = evt_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    cnt_d     = '0;
                    evt_idx_d = '0;
                    state_d   = S_ARMED;
                end
            end
            S_ARMED: begin
                if (push_req) begin
                    evt_idx_d = evt_idx_inc;
                    state_d   = (evt_idx_inc == 2'(MAX_EVT)) ? S_HOLD : S_REARM;
                end
            end
            S_REARM: begin
                if (hold_done && !trig_s_q) state_d = S_ARMED;
            end
            S_HOLD:  ;
            default: state_d = S_IDLE;
        endcase

        // Window close overrides whatever transition was chosen above.
        if (active) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (win_last) state_d = S_IDLE;
        end
    end

    always_comb begin
        rst_auto_d = (state_d == S_REARM) && !gate_s_q;
        hold_d     = '0;
        if (state_q == S_REARM && state_d == S_REARM) begin
            hold_d = hold_q;
            if (rst_auto_q && !hold_done) hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            evt_idx_q  <= '0;
            hold_q     <= '0;
            rst_auto_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            evt_idx_q  <= evt_idx_d;
            hold_q     <= hold_d;
            rst_auto_q <= rst_auto_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [EVT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full, pop, push_ok;

    assign full    = (occ_q == OCC_W'(FIFO_DEPTH));
    assign pop     = evt_valid && evt_ready;
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        occ_d = occ_q;
        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: storage is not reset; the read mux below masks stale entries while empty.
    always_ff @(posedge clk_250M) begin
        if (push_ok) mem[wr_ptr_q] <= {evt_idx_q, cnt_q, spad_int};
    end

    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q <= occ_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign evt_valid = (occ_q != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr_q] : '0;
    assign rst_auto  = rst_auto_q;
    assign win_done  = win_last;
    assign evt_drop  = push_req && !push_ok;

endmodule

// File: doc/spad_event_capture.md
Name: spad_event_capture

Overview:
- Sits directly downstream of the SPAD front-end in clk_250M.
- Synchronises the asynchronous trig/time_gate outputs and timestamps each photon against a coarse cycle counter started by TDC_start.
- Latches the 16-bit intensity word and pushes {index, timestamp, intensity} into a small event FIFO.
- Generates rst_auto = (!time_gate) & sync to re-arm the SPAD between photons.

Parameters:
CNT_W, 10, coarse counter / timestamp width (4 ns LSB)
WINDOW_CYC, 512, measurement window length in clk_250M cycles (2048 ns)
RST_CYC, 2, minimum cycles rst_auto is held high per re-arm
MAX_EVT, 3, photons accepted per window (<=3, index is 2 bits)
FIFO_DEPTH, 4, event FIFO entries, power of 2

Ports:
clk_250M  in  1  system clock, 250 MHz
rst_n  in  1  reset; asynchronous assert, active-low
TDC_start  in  1  synchronous start request; rising edge opens a window
trig  in  1  async level from SPAD; high after photon until rst_auto
time_gate  in  1  async gate pulse from SPAD; blocks rst_auto while high
spad_int  in  16  intensity word, stable while trig high
rst_auto  out  1  registered SPAD re-arm pulse
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
evt_data  out  CNT_W+18  {evt_idx[1:0], tstamp[CNT_W-1:0], intensity[15:0]}
win_done  out  1  one-cycle pulse at window close
evt_drop  out  1  one-cycle pulse when an event is lost to a full FIFO

Behaviour:
- Reset (rst_n low, async): state IDLE, cnt=0, evt_idx=0, FIFO empty; rst_auto=0, evt_valid=0, evt_data=0, win_done=0, evt_drop=0.
- trig and time_gate each pass through 2-FF synchronisers (trig_s, gate_s). trig_rise = trig_s & !trig_s_d. TDC_start is edge-detected via one register.
- FSM states: IDLE, ARMED, REARM, HOLD.
- IDLE:
  - TDC_start rising -> cnt<=0, evt_idx<=0, go ARMED.
  - TDC_start rising edges in any other state are ignored.
- Window counter: cnt increments every cycle in ARMED/REARM/HOLD. When cnt==WINDOW_CYC-1:
  - Go IDLE next cycle; win_done=1 that cycle.
  - If in REARM with rst_auto high, rst_auto drops on the same edge.
  - Window close has priority over every other transition.
- ARMED, trig_rise:
  - Push {evt_idx, cnt, spad_int} (cnt as sampled that cycle; the 2-cycle sync latency is not compensated).
  - evt_idx++.
  - If the new evt_idx==MAX_EVT go HOLD, else go REARM.
  - trig_rise on the window-close cycle is still pushed.
- REARM:
  - rst_auto = !gate_s, registered.
  - A hold counter counts cycles with rst_auto high.
  - Exit to ARMED when hold count >= RST_CYC and trig_s==0.
  - trig_rise seen in REARM is not captured (SPAD still resetting).
- HOLD: rst_auto=0; trig ignored until window close.
- FIFO push rules:
  - Push accepted if !full, or if full and a pop occurs the same cycle.
  - Otherwise the event is dropped: evt_drop=1 for one cycle. evt_idx still increments and the FSM still advances.
- FIFO read: evt_valid = !empty; evt_data = head entry (0 when empty). Pop on evt_valid & evt_ready. Simultaneous push and pop keep occupancy constant.
- FIFO pointers wrap modulo FIFO_DEPTH; occupancy is held in a CNT of log2(FIFO_DEPTH)+1 bits.
- rst_n deasserted mid-window: no partial state survives; the next window needs a new TDC_start edge.

Test Plan:
- Reset, then TDC_start pulse; assert trig at +100 ns with spad_int=16'h0007 -> evt_data={2'd0, tstamp≈25+2, 16'h0007}; rst_auto high ≥2 cycles once time_gate low, then low after trig falls; state ARMED.
- Three photons at 100/400/900 ns with spad_int 5/6/7 -> three events, idx 0,1,2, timestamps increasing; fourth trig at 1200 ns ignored (HOLD); win_done pulses at cycle 511.
- Hold time_gate high for 10 cycles after trig -> rst_auto stays 0 until gate_s drops, then high for 2 cycles.
- evt_ready=0, 2 windows × 3 photons -> first 4 stored, events 5 and 6 each pulse evt_drop; drain with evt_ready=1 returns the 4 in order.
- FIFO full with evt_ready=1 on the push cycle -> no drop, occupancy stays 4.
- rst_n low while in REARM with rst_auto=1 -> rst_auto, evt_valid, and FIFO clear immediately; no events until the next TDC_start.
